// File: rtl/chronologic_pkg.sv
// chronologic: shared types and defaults for the one-hot
// compliance monitor and its helpers.
package chronologic_pkg;

  localparam int DEF_WIDTH = 5;
  localparam int DEF_CNT_W = 16;

  typedef enum logic [1:0] {
    NONE      = 2'd0,
    ZERO_HOT  = 2'd1,
    MULTI_HOT = 2'd2
  } fail_code_t;

endpackage

// File: rtl/chronologic_popcnt.sv
// chronologic_popcnt: combinational zero/multi-hot detector,
// reusable by any one-hot style checker.
module chronologic_popcnt #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] vec_i,
  output logic             is_zero_o,
  output logic             is_multi_o
);

  logic [WIDTH-1:0] low_clr;

  // Clearing the lowest set bit leaves residue iff >=2 bits set.
  assign low_clr    = vec_i & (vec_i - WIDTH'(1));
  assign is_zero_o  = ~|vec_i;
  assign is_multi_o = |low_clr;

endmodule

// File: rtl/chronologic.sv
// chronologic: registered one-hot compliance monitor with
// classification, sticky error, first-fail capture and stats.
module chronologic
  import chronologic_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic [WIDTH-1:0] b,
  input  logic             clr,
  output logic             pass,
  output logic             fail,
  output logic             vacuous,
  output fail_code_t       fail_code,
  output logic             err_sticky,
  output logic [WIDTH-1:0] first_fail_vec,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] vac_cnt
);

  logic is_zero, is_multi;

  logic             pass_d, pass_q;
  logic             fail_d, fail_q;
  logic             vac_d, vac_q;
  fail_code_t       code_d, code_q;
  logic             sticky_d, sticky_q;
  logic [WIDTH-1:0] first_d, first_q;
  logic [CNT_W-1:0] pcnt_d, pcnt_q;
  logic [CNT_W-1:0] fcnt_d, fcnt_q;
  logic [CNT_W-1:0] vcnt_d, vcnt_q;

  chronologic_popcnt #(
    .WIDTH(WIDTH)
  ) u_popcnt (
    .vec_i     (b),
    .is_zero_o (is_zero),
    .is_multi_o(is_multi)
  );

  always_comb begin
    pass_d = a & ~is_zero & ~is_multi;
    fail_d = a & (is_zero | is_multi);
    vac_d  = ~a;
    code_d = NONE;
    if (a) begin
      unique case (1'b1)
        is_zero:  code_d = ZERO_HOT;
        is_multi: code_d = MULTI_HOT;
        default:  code_d = NONE;
      endcase
    end
  end

  // Clear wins over capture and increment on the same edge.
  always_comb begin
    sticky_d = sticky_q;
    first_d  = first_q;
    pcnt_d   = pcnt_q;
    fcnt_d   = fcnt_q;
    vcnt_d   = vcnt_q;
    if (clr) begin
      sticky_d = 1'b0;
      first_d  = '0;
      pcnt_d   = '0;
      fcnt_d   = '0;
      vcnt_d   = '0;
    end else begin
      if (fail_d && !sticky_q) first_d = b;
      if (fail_d) sticky_d = 1'b1;
      if (pass_d && pcnt_q != '1)
        pcnt_d = pcnt_q + CNT_W'(1);
      if (fail_d && fcnt_q != '1)
        fcnt_d = fcnt_q + CNT_W'(1);
      if (vac_d && vcnt_q != '1)
        vcnt_d = vcnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_q   <= 1'b0;
      fail_q   <= 1'b0;
      vac_q    <= 1'b0;
      code_q   <= NONE;
      sticky_q <= 1'b0;
      first_q  <= '0;
      pcnt_q   <= '0;
      fcnt_q   <= '0;
      vcnt_q   <= '0;
    end else begin
      pass_q   <= pass_d;
      fail_q   <= fail_d;
      vac_q    <= vac_d;
      code_q   <= code_d;
      sticky_q <= sticky_d;
      first_q  <= first_d;
      pcnt_q   <= pcnt_d;
      fcnt_q   <= fcnt_d;
      vcnt_q   <= vcnt_d;
    end
  end

  assign pass           = pass_q;
  assign fail           = fail_q;
  assign vacuous        = vac_q;
  assign fail_code      = code_q;
  assign err_sticky     = sticky_q;
  assign first_fail_vec = first_q;
  assign pass_cnt       = pcnt_q;
  assign fail_cnt       = fcnt_q;
  assign vac_cnt        = vcnt_q;

endmodule

// File: tb/tb_chronologic.sv
// tb_chronologic: randomized scoreboard bench for the one-hot
// monitor against a popcount-level reference model.
module tb_chronologic;
  import chronologic_pkg::*;

  localparam int W    = 5;
  localparam int CW   = 3;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          a     = 1'b0;
  logic [W-1:0]  b     = '0;
  logic          clr   = 1'b0;
  logic          pass, fail, vacuous, err_sticky;
  fail_code_t    fail_code;
  logic [W-1:0]  first_fail_vec;
  logic [CW-1:0] pass_cnt, fail_cnt, vac_cnt;

  chronologic #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .a             (a),
    .b             (b),
    .clr           (clr),
    .pass          (pass),
    .fail          (fail),
    .vacuous       (vacuous),
    .fail_code     (fail_code),
    .err_sticky    (err_sticky),
    .first_fail_vec(first_fail_vec),
    .pass_cnt      (pass_cnt),
    .fail_cnt      (fail_cnt),
    .vac_cnt       (vac_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit p, f, v, st;
    int code, first, pc, fc, vc;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  bit m_st;
  int m_first, m_pc, m_fc, m_vc;

  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_first = 0; m_pc = 0; m_fc = 0; m_vc = 0;
  endtask

  task automatic drive(bit ia, logic [W-1:0] ib, bit iclr);
    exp_t e;
    int n;
    a = ia; b = ib; clr = iclr;
    n = $countones(ib);
    e.v = !ia;
    e.p = ia && n == 1;
    e.f = ia && n != 1;
    e.code = !ia ? 0 : (n == 0 ? 1 : (n > 1 ? 2 : 0));
    if (iclr) model_reset();
    else begin
      if (e.f && !m_st) m_first = int'(ib);
      if (e.f) m_st = 1;
      if (e.p && m_pc < CMAX) m_pc++;
      if (e.f && m_fc < CMAX) m_fc++;
      if (e.v && m_vc < CMAX) m_vc++;
    end
    e.st = m_st; e.first = m_first;
    e.pc = m_pc; e.fc = m_fc; e.vc = m_vc;
    q.push_back(e);
  endtask

  task automatic step(bit ia, logic [W-1:0] ib, bit iclr);
    @(negedge clk);
    drive(ia, ib, iclr);
  endtask

  task automatic rst_chk(string tag);
    chk({tag, ".pass"}, int'(pass), 0);
    chk({tag, ".fail"}, int'(fail), 0);
    chk({tag, ".vac"}, int'(vacuous), 0);
    chk({tag, ".code"}, int'(fail_code), 0);
    chk({tag, ".sticky"}, int'(err_sticky), 0);
    chk({tag, ".first"}, int'(first_fail_vec), 0);
    chk({tag, ".pcnt"}, int'(pass_cnt), 0);
    chk({tag, ".fcnt"}, int'(fail_cnt), 0);
    chk({tag, ".vcnt"}, int'(vac_cnt), 0);
  endtask

  // Monitor: one expected record per sampled edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && q.size() > 0) begin
        e = q.pop_front();
        chk("pass", int'(pass), int'(e.p));
        chk("fail", int'(fail), int'(e.f));
        chk("vacuous", int'(vacuous), int'(e.v));
        chk("fail_code", int'(fail_code), e.code);
        chk("err_sticky", int'(err_sticky), int'(e.st));
        chk("first_fail_vec", int'(first_fail_vec), e.first);
        chk("pass_cnt", int'(pass_cnt), e.pc);
        chk("fail_cnt", int'(fail_cnt), e.fc);
        chk("vac_cnt", int'(vac_cnt), e.vc);
      end
    end
  end

  task automatic rand_run(int n);
    logic [W-1:0] rb;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 1) == 1) rb = W'(1) << $urandom_range(0, W - 1);
      else rb = W'($urandom);
      step($urandom_range(0, 3) != 0, rb, $urandom_range(0, 19) == 0);
    end
  endtask

  initial begin
    int waited;
    model_reset();
    #1;
    rst_chk("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 5'b00100, 1'b0);
    step(1'b0, 5'b01000, 1'b0);
    step(1'b0, 5'b01100, 1'b0);
    step(1'b0, 5'b00000, 1'b0);
    step(1'b1, 5'b11000, 1'b0);
    step(1'b1, 5'b11100, 1'b0);
    step(1'b1, 5'b00000, 1'b0);
    step(1'b1, 5'b00100, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, 5'b10000, 1'b0);
    step(1'b0, 5'b11111, 1'b0);
    for (int i = 0; i < 9; i++) step(1'b1, 5'b00011, 1'b0);
    rand_run(400);
    // Async reset landing between edges.
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    rst_chk("midreset");
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 5'b00100, 1'b0);
    rand_run(400);
    waited = 0;
    while (q.size() > 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    #2;
    chk("drain", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
